pipelined_addsub: RTL and testbench

- Parametrised successor to the single-cycle 32-bit ripple adder used by the NPC ALU.
- Performs add, subtract, and add/subtract-with-carry on DATA_WIDTH-bit operands.
- Splits the carry chain into STAGES equal chunks, with one register stage per chunk.
- Uses a valid/ready handshake on both sides and returns full-width flags (carry, zero, overflow, negative, slt, sltu) with each result. It sits between the decode/issue stage and the EXU writeback.

---
 rtl/pipelined_addsub_if.sv | 33 +++
 rtl/pipelined_addsub.sv | 144 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_if.sv
// Operand/result bus of the pipelined adder: request side (valid/ready, operands,
// op controls) and response side (valid/ready, result, flags).
interface pipelined_addsub_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  op_sub;
    logic                  cin_en;
    logic                  cin;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  carry;
    logic                  zero;
    logic                  overflow;
    logic                  negative;
    logic                  slt;
    logic                  sltu;

    modport master (
        output in_valid, a, b, op_sub, cin_en, cin, out_ready,
        input  in_ready, out_valid, result, carry, zero, overflow, negative, slt, sltu
    );

    modport slave (
        input  in_valid, a, b, op_sub, cin_en, cin, out_ready,
        output in_ready, out_valid, result, carry, zero, overflow, negative, slt, sltu
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Add/subtract with the carry chain split into STAGES chunks, one register stage per
// chunk, valid/ready on both sides and full-width flags registered with each result.
module pipelined_addsub #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STAGES     = 2
) (
    input  logic              clk,
    input  logic              rst,
    pipelined_addsub_if.slave bus
);
    localparam int unsigned CHUNK = DATA_WIDTH / STAGES;
    localparam int unsigned MSB   = DATA_WIDTH - 1;
    localparam int unsigned LAST  = STAGES - 1;

    logic [STAGES-1:0]     v_q, v_d;
    logic [STAGES:0]       ready;
    logic [DATA_WIDTH-1:0] a_q   [STAGES];
    logic [DATA_WIDTH-1:0] a_d   [STAGES];
    logic [DATA_WIDTH-1:0] be_q  [STAGES];
    logic [DATA_WIDTH-1:0] be_d  [STAGES];
    logic [DATA_WIDTH-1:0] sum_q [STAGES];
    logic [DATA_WIDTH-1:0] sum_d [STAGES];
    logic [STAGES-1:0]     c_q, c_d;

    logic carry_q, carry_d;
    logic zero_q, zero_d;
    logic ovf_q, ovf_d;
    logic neg_q, neg_d;
    logic slt_q, slt_d;
    logic sltu_q, sltu_d;

    logic [DATA_WIDTH-1:0] a_in    [STAGES];
    logic [DATA_WIDTH-1:0] be_in   [STAGES];
    logic [DATA_WIDTH-1:0] sum_in  [STAGES];
    logic [DATA_WIDTH-1:0] sum_new [STAGES];
    logic [CHUNK:0]        chunk_sum [STAGES];
    logic [STAGES-1:0]     c_in, v_in, load;
    logic                  ovf_new;

    // Ready ripples back from the consumer so an empty stage always accepts.
    always_comb begin
        ready[STAGES] = bus.out_ready;
        for (int unsigned i = 0; i < STAGES; i++) begin
            ready[LAST-i] = ~v_q[LAST-i] | ready[STAGES-i];
        end
    end

    always_comb begin
        a_in[0]   = bus.a;
        be_in[0]  = bus.op_sub ? ~bus.b : bus.b;
        sum_in[0] = '0;
        c_in[0]   = bus.cin_en ? bus.cin : bus.op_sub;
        v_in[0]   = bus.in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            a_in[k]   = a_q[k-1];
            be_in[k]  = be_q[k-1];
            sum_in[k] = sum_q[k-1];
            c_in[k]   = c_q[k-1];
            v_in[k]   = v_q[k-1];
        end

        for (int unsigned k = 0; k < STAGES; k++) begin
            chunk_sum[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
                         + {1'b0, be_in[k][k*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, c_in[k]};
            sum_new[k]                   = sum_in[k];
            sum_new[k][k*CHUNK +: CHUNK] = chunk_sum[k][CHUNK-1:0];

            load[k] = ready[k] & v_in[k];
            v_d[k]  = ready[k] ? v_in[k] : v_q[k];
            a_d[k]   = a_q[k];
            be_d[k]  = be_q[k];
            sum_d[k] = sum_q[k];
            c_d[k]   = c_q[k];
            if (load[k]) begin
                a_d[k]   = a_in[k];
                be_d[k]  = be_in[k];
                sum_d[k] = sum_new[k];
                c_d[k]   = chunk_sum[k][CHUNK];
            end
        end
    end

    // Flags come from the beat entering the last stage so they land with its result.
    always_comb begin
        ovf_new = (a_in[LAST][MSB] == be_in[LAST][MSB]) && (sum_new[LAST][MSB] != a_in[LAST][MSB]);
        carry_d = carry_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        neg_d   = neg_q;
        slt_d   = slt_q;
        sltu_d  = sltu_q;
        if (load[LAST]) begin
            carry_d = chunk_sum[LAST][CHUNK];
            zero_d  = ~|sum_new[LAST];
            ovf_d   = ovf_new;
            neg_d   = sum_new[LAST][MSB];
            slt_d   = sum_new[LAST][MSB] ^ ovf_new;
            sltu_d  = ~chunk_sum[LAST][CHUNK];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q     <= '0;
            c_q     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            slt_q   <= 1'b0;
            sltu_q  <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                be_q[k]  <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            v_q     <= v_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
            slt_q   <= slt_d;
            sltu_q  <= sltu_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                be_q[k]  <= be_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign bus.in_ready  = ready[0];
    assign bus.out_valid = v_q[LAST];
    assign bus.result    = sum_q[LAST];
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.negative  = neg_q;
    assign bus.slt       = slt_q;
    assign bus.sltu      = sltu_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: four configurations (32/2, 32/1, 32/4, 8/2) checked
// against an arithmetic reference model, with directed corner cases and random traffic.
module tb_pipelined_addsub;
    logic clk;
    logic rst;

    int W_OF [4] = '{32, 32, 32, 8};
    int S_OF [4] = '{2, 1, 4, 2};

    logic [3:0]  iv, ordy, sub_s, cen_s, cin_s;
    logic [31:0] a_s [4];
    logic [31:0] b_s [4];
    logic [3:0]  ir, ovl;
    logic [31:0] res [4];
    logic [5:0]  fl  [4];

    int checks = 0;
    int errors = 0;

    logic [37:0] expq [4][$];
    logic        held_v [4];
    logic [31:0] held_r [4];
    logic [5:0]  held_f [4];
    int          outx   [4];

    pipelined_addsub_if #(.DATA_WIDTH(32)) if0 ();
    pipelined_addsub_if #(.DATA_WIDTH(32)) if1 ();
    pipelined_addsub_if #(.DATA_WIDTH(32)) if2 ();
    pipelined_addsub_if #(.DATA_WIDTH(8))  if3 ();

    pipelined_addsub #(.DATA_WIDTH(32), .STAGES(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    pipelined_addsub #(.DATA_WIDTH(32), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    pipelined_addsub #(.DATA_WIDTH(32), .STAGES(4)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    pipelined_addsub #(.DATA_WIDTH(8),  .STAGES(2)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    assign if0.in_valid = iv[0];  assign if0.a = a_s[0];  assign if0.b = b_s[0];
    assign if0.op_sub = sub_s[0]; assign if0.cin_en = cen_s[0]; assign if0.cin = cin_s[0];
    assign if0.out_ready = ordy[0];
    assign ir[0] = if0.in_ready;  assign ovl[0] = if0.out_valid;  assign res[0] = if0.result;
    assign fl[0] = {if0.carry, if0.zero, if0.overflow, if0.negative, if0.slt, if0.sltu};

    assign if1.in_valid = iv[1];  assign if1.a = a_s[1];  assign if1.b = b_s[1];
    assign if1.op_sub = sub_s[1]; assign if1.cin_en = cen_s[1]; assign if1.cin = cin_s[1];
    assign if1.out_ready = ordy[1];
    assign ir[1] = if1.in_ready;  assign ovl[1] = if1.out_valid;  assign res[1] = if1.result;
    assign fl[1] = {if1.carry, if1.zero, if1.overflow, if1.negative, if1.slt, if1.sltu};

    assign if2.in_valid = iv[2];  assign if2.a = a_s[2];  assign if2.b = b_s[2];
    assign if2.op_sub = sub_s[2]; assign if2.cin_en = cen_s[2]; assign if2.cin = cin_s[2];
    assign if2.out_ready = ordy[2];
    assign ir[2] = if2.in_ready;  assign ovl[2] = if2.out_valid;  assign res[2] = if2.result;
    assign fl[2] = {if2.carry, if2.zero, if2.overflow, if2.negative, if2.slt, if2.sltu};

    assign if3.in_valid = iv[3];  assign if3.a = a_s[3][7:0];  assign if3.b = b_s[3][7:0];
    assign if3.op_sub = sub_s[3]; assign if3.cin_en = cen_s[3]; assign if3.cin = cin_s[3];
    assign if3.out_ready = ordy[3];
    assign ir[3] = if3.in_ready;  assign ovl[3] = if3.out_valid;  assign res[3] = {24'h0, if3.result};
    assign fl[3] = {if3.carry, if3.zero, if3.overflow, if3.negative, if3.slt, if3.sltu};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on a w-bit machine; flags from true values.
    // Returns {carry, zero, overflow, negative, slt, sltu, result[31:0]}.
    function automatic logic [37:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic cen, input logic cin,
                                          input int w);
        longint m, au, bu, be, s, lim, sa, sbe, t, c0;
        logic [5:0] f;
        m   = (longint'(1) << w) - 1;
        au  = longint'(a) & m;
        bu  = longint'(b) & m;
        be  = sub ? (m - bu) : bu;
        c0  = cen ? longint'(cin) : longint'(sub);
        s   = au + be + c0;
        lim = longint'(1) << (w - 1);
        sa  = (au >= lim) ? au - 2 * lim : au;
        sbe = (be >= lim) ? be - 2 * lim : be;
        t   = sa + sbe + c0;
        f[5] = (s > m);
        f[4] = ((s & m) == 0);
        f[3] = (t >= lim) || (t < -lim);
        f[2] = ((s & m) >= lim);
        f[1] = (t < 0);
        f[0] = !(s > m);
        return {f, 32'(s & m)};
    endfunction

    task automatic check(input string tag, input int i, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[dut%0d]: observed %h expected %h", tag, i, got, exp);
        end
    endtask

    // One clock cycle; inputs were set after the previous falling edge.
    task automatic cyc();
        logic [37:0] e;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                expq[i].delete();
                held_v[i] = 1'b0;
            end else begin
                if (held_v[i]) begin
                    check("hold_valid", i, 64'(ovl[i]), 64'd1);
                    check("hold_result", i, 64'(res[i]), 64'(held_r[i]));
                    check("hold_flags", i, 64'(fl[i]), 64'(held_f[i]));
                end
                if (ovl[i] && ordy[i]) begin
                    outx[i]++;
                    check("out_has_input", i, 64'(expq[i].size() != 0), 64'd1);
                    if (expq[i].size() != 0) begin
                        e = expq[i].pop_front();
                        check("result", i, 64'(res[i]), 64'(e[31:0]));
                        check("flags", i, 64'(fl[i]), 64'(e[37:32]));
                    end
                end
                held_v[i] = ovl[i] && !ordy[i];
                held_r[i] = res[i];
                held_f[i] = fl[i];
                if (iv[i] && ir[i])
                    expq[i].push_back(model(a_s[i], b_s[i], sub_s[i], cen_s[i], cin_s[i], W_OF[i]));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cen;
        logic        cin;
        logic [31:0] r;
        logic [5:0]  f;
    } vec_t;

    vec_t t32 [7];
    vec_t t8  [7];

    task automatic set_op(input int i, input vec_t v);
        a_s[i] = v.a; b_s[i] = v.b; sub_s[i] = v.sub; cen_s[i] = v.cen; cin_s[i] = v.cin;
    endtask

    task automatic apply_wait(input int i, input vec_t v);
        int n;
        iv[i] = 1'b1;
        ordy[i] = 1'b1;
        set_op(i, v);
        cyc();
        iv[i] = 1'b0;
        n = 1;
        while (!ovl[i] && n < 12) begin
            cyc();
            n++;
        end
        check("latency", i, 64'(n), 64'(S_OF[i]));
        check("dir_result", i, 64'(res[i]), 64'(v.r));
        check("dir_flags", i, 64'(fl[i]), 64'(v.f));
        cyc();
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h0000_007F;
            5: return 32'h0000_0080;
            default: return $urandom;
        endcase
    endfunction

    task automatic rnd_op(input int i);
        a_s[i] = rnd_operand();
        b_s[i] = rnd_operand();
        sub_s[i] = 1'($urandom_range(0, 1));
        cen_s[i] = ($urandom_range(0, 3) == 0);
        cin_s[i] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int k, x0;
        logic acc;
        vec_t ops [5];

        t32[0] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 6'b110000};
        t32[1] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 6'b001101};
        t32[2] = '{32'h8000_0000, 32'h1, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 6'b101010};
        t32[3] = '{32'h5,         32'h7, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 6'b000111};
        t32[4] = '{32'h7,         32'h7, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 6'b110000};
        t32[5] = '{32'h0000_FFFF, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0001_0000, 6'b000001};
        t32[6] = '{32'hA,         32'h3, 1'b1, 1'b1, 1'b0, 32'h0000_0006, 6'b100000};
        t8[0]  = '{32'hFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h00, 6'b110000};
        t8[1]  = '{32'h7F, 32'h1, 1'b0, 1'b0, 1'b0, 32'h80, 6'b001101};
        t8[2]  = '{32'h80, 32'h1, 1'b1, 1'b0, 1'b0, 32'h7F, 6'b101010};
        t8[3]  = '{32'h5,  32'h7, 1'b1, 1'b0, 1'b0, 32'hFE, 6'b000111};
        t8[4]  = '{32'h7,  32'h7, 1'b1, 1'b0, 1'b0, 32'h00, 6'b110000};
        t8[5]  = '{32'h0F, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10, 6'b000001};
        t8[6]  = '{32'hA,  32'h3, 1'b1, 1'b1, 1'b0, 32'h06, 6'b100000};

        rst = 1'b1;
        iv = '0; ordy = '0; sub_s = '0; cen_s = '0; cin_s = '0;
        for (int i = 0; i < 4; i++) begin
            a_s[i] = '0; b_s[i] = '0; held_v[i] = 1'b0; outx[i] = 0;
        end
        @(negedge clk);
        iv = '1;
        cyc();
        cyc();
        for (int i = 0; i < 4; i++) begin
            check("rst_out_valid", i, 64'(ovl[i]), 64'd0);
            check("rst_in_ready", i, 64'(ir[i]), 64'd1);
            check("rst_result", i, 64'(res[i]), 64'd0);
            check("rst_flags", i, 64'(fl[i]), 64'd0);
        end
        rst = 1'b0;
        iv = '0;
        ordy = '1;

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 7; j++)
                apply_wait(i, (i == 3) ? t8[j] : t32[j]);

        // Backpressure on the 2-stage instance: two beats fill it, then it stalls.
        for (int j = 0; j < 5; j++)
            ops[j] = '{$urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 32'h0, 6'h0};
        ordy[0] = 1'b0;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            iv[0] = (k < 5);
            set_op(0, ops[k]);
            #1;
            acc = iv[0] && ir[0];
            if (c >= 2) check("in_ready_full", 0, 64'(ir[0]), 64'd0);
            cyc();
            if (acc) k++;
        end
        check("accepted_while_stalled", 0, 64'(k), 64'd2);
        ordy[0] = 1'b1;
        x0 = outx[0];
        for (int c = 0; c < 5; c++) begin
            iv[0] = (k < 5);
            if (k < 5) set_op(0, ops[k]);
            #1;
            acc = iv[0] && ir[0];
            cyc();
            if (acc) k++;
        end
        check("release_outputs", 0, 64'(outx[0] - x0), 64'd5);
        check("release_accepted", 0, 64'(k), 64'd5);
        iv[0] = 1'b0;
        cyc();
        check("bp_drained", 0, 64'(expq[0].size()), 64'd0);

        // Reset with two beats in flight: nothing from before it may emerge.
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        set_op(0, t32[1]);
        cyc();
        set_op(0, t32[3]);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        iv[0] = 1'b0;
        check("rst_flight_out_valid", 0, 64'(ovl[0]), 64'd0);
        check("rst_flight_in_ready", 0, 64'(ir[0]), 64'd1);
        check("rst_flight_result", 0, 64'(res[0]), 64'd0);
        ordy[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            check("no_stale_out", 0, 64'(ovl[0]), 64'd0);
        end

        // Random traffic on all four configurations, with one mid-run reset.
        for (int c = 0; c < 6000; c++) begin
            rst = (c == 3000);
            for (int i = 0; i < 4; i++) begin
                iv[i] = ($urandom_range(0, 3) != 0);
                ordy[i] = ($urandom_range(0, 3) != 0);
                rnd_op(i);
            end
            cyc();
        end
        rst = 1'b0;
        iv = '0;
        ordy = '1;
        for (int c = 0; c < 8; c++) cyc();
        for (int i = 0; i < 4; i++)
            check("final_drained", i, 64'(expq[i].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
